// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point helpers for the neural network datapath blocks.
// Holds default widths, the evaluation state type and the output slicing function.
package nn_fixed_pkg;

  localparam int FRAC_DEF = 10;
  localparam int DW_DEF   = 16;
  localparam int SAT_W    = 64;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } nn_state_t;

  typedef struct packed {
    logic             ovf;
    logic [SAT_W-1:0] z;
  } sat_res_t;

  function automatic int clog2(input int unsigned n);
    int          r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // z holds the result in its low ow bits; callers slice off what they need.
  function automatic sat_res_t sat_slice(input logic signed [SAT_W-1:0] value,
                                         input int unsigned shift,
                                         input int unsigned ow,
                                         input logic sat_en);
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t                r;
    s     = value >>> shift;
    hi    = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    r.ovf = (s > hi) || (s < lo);
    if (r.ovf && sat_en) r.z = (s < 0) ? lo : hi;
    else                 r.z = s;
    return r;
  endfunction

endpackage

// File: rtl/nn_sat_out.sv
// Output stage: floor-shifts the accumulator to the output LSB, range-checks
// it against the signed OW range and either clamps or wraps.
module nn_sat_out
  import nn_fixed_pkg::*;
#(
  parameter int ACCW   = 24,
  parameter int OSHIFT = 6,
  parameter int OW     = 8,
  parameter bit SAT_EN = 1'b1
) (
  input  logic signed [ACCW-1:0] acc,
  output logic        [OW-1:0]   z,
  output logic                   ovf
);

  sat_res_t res;

  always_comb begin
    res = sat_slice(SAT_W'(acc), OSHIFT, OW, SAT_EN);
  end

  assign z   = OW'(res.z);
  assign ovf = res.ovf;

endmodule

// File: rtl/neuron_mac_sat.sv
// Serial neuron: accumulates N_IN (a,w) products plus a bias through one shared
// multiplier, then presents one saturated fixed-point result per evaluation.
module neuron_mac_sat
  import nn_fixed_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int DW     = DW_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int OW     = 8,
  parameter int OSHIFT = 6,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] a_in,
  input  logic signed [DW-1:0] w_in,
  input  logic signed [DW-1:0] b_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic        [OW-1:0] z_out,
  output logic                 ovf
);

  localparam int PW   = 2 * DW - FRAC;
  localparam int ACCW = PW + clog2(N_IN + 1);
  localparam int CW   = (N_IN > 1) ? clog2(N_IN) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_IN - 1);

  nn_state_t               state;
  logic [CW-1:0]           cnt;
  logic signed [ACCW-1:0]  acc;

  logic signed [2*DW-1:0]  prod_full;
  logic signed [PW-1:0]    prod;
  logic signed [ACCW-1:0]  prod_ext;
  logic signed [ACCW-1:0]  bias_ext;
  logic signed [ACCW-1:0]  acc_base;
  logic        [OW-1:0]    z_raw;
  logic                    ovf_raw;

  // Only sign bits are dropped after the floor shift, so PW holds the product exactly.
  assign prod_full = (2 * DW)'(a_in) * (2 * DW)'(w_in);
  assign prod      = PW'(prod_full >>> FRAC);
  assign prod_ext  = ACCW'(prod);
  assign bias_ext  = ACCW'(b_in);
  assign acc_base  = (cnt == '0) ? bias_ext : acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ACC;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            acc <= acc_base + prod_ext;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= ACC;
            acc   <= '0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  nn_sat_out #(
    .ACCW  (ACCW),
    .OSHIFT(OSHIFT),
    .OW    (OW),
    .SAT_EN(SAT_EN)
  ) u_sat_out (
    .acc(acc),
    .z  (z_raw),
    .ovf(ovf_raw)
  );

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign z_out     = out_valid ? z_raw : '0;
  assign ovf       = out_valid & ovf_raw;

endmodule

// File: tb/tb_neuron_mac_sat.sv
// Self-checking bench for neuron_mac_sat: directed cases on saturating, wrapping
// and single-input builds, then randomized evaluations on 1- and 8-input builds.
module tb_neuron_mac_sat;

  localparam int ND = 4;

  logic clk = 1'b0;
  logic reset;

  logic               in_valid  [ND];
  logic               in_ready  [ND];
  logic               out_valid [ND];
  logic               out_ready [ND];
  logic               ovf       [ND];
  logic signed [15:0] a_in      [ND];
  logic signed [15:0] w_in      [ND];
  logic signed [15:0] b_in      [ND];
  logic        [7:0]  z_out     [ND];

  logic signed [15:0] ta  [8];
  logic signed [15:0] tw  [8];
  logic signed [15:0] tbv [8];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  neuron_mac_sat #(.N_IN(3)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a_in(a_in[0]), .w_in(w_in[0]), .b_in(b_in[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .z_out(z_out[0]), .ovf(ovf[0]));

  neuron_mac_sat #(.N_IN(3), .SAT_EN(1'b0)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a_in(a_in[1]), .w_in(w_in[1]), .b_in(b_in[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .z_out(z_out[1]), .ovf(ovf[1]));

  neuron_mac_sat #(.N_IN(1)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a_in(a_in[2]), .w_in(w_in[2]), .b_in(b_in[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .z_out(z_out[2]), .ovf(ovf[2]));

  neuron_mac_sat #(.N_IN(8)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .a_in(a_in[3]), .w_in(w_in[3]), .b_in(b_in[3]), .out_valid(out_valid[3]),
    .out_ready(out_ready[3]), .z_out(z_out[3]), .ovf(ovf[3]));

  // Reference: exact integer sum of bias and floored products, floor shift, then clamp or wrap.
  function automatic void model(input int d, input int n, output logic [7:0] ez, output logic eovf);
    longint sum;
    longint s;
    sum = longint'(tbv[0]);
    for (int i = 0; i < n; i++) sum += (longint'(ta[i]) * longint'(tw[i])) >>> 10;
    s    = sum >>> 6;
    eovf = (s > 127) || (s < -128);
    if (eovf && d != 1) ez = (s < 0) ? 8'h80 : 8'h7F;
    else                ez = 8'(s);
  endfunction

  task automatic run_eval(input int d, input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      int gaps;
      gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      in_valid[d] = 1'b0;
      repeat (gaps) begin
        @(posedge clk); #1;
      end
      in_valid[d] = 1'b1;
      a_in[d] = ta[i];
      w_in[d] = tw[i];
      b_in[d] = tbv[i];
      @(posedge clk); #1;
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic finish_eval(input int d);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0;
      a_in[d] = '0; w_in[d] = '0; b_in[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      checks += 4;
      if (in_ready[d] !== 1'b1)  begin errors++; $display("FAIL reset_in_ready dut%0d: got %b want 1", d, in_ready[d]); end
      if (out_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d: got %b want 0", d, out_valid[d]); end
      if (z_out[d] !== 8'h00)    begin errors++; $display("FAIL reset_z dut%0d: got %h want 00", d, z_out[d]); end
      if (ovf[d] !== 1'b0)       begin errors++; $display("FAIL reset_ovf dut%0d: got %b want 0", d, ovf[d]); end
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_mac();
    for (int i = 0; i < 3; i++) begin
      in_valid[0] = 1'b1; a_in[0] = 16'sd1024; w_in[0] = 16'sd1024; b_in[0] = '0;
      checks++;
      if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL early_valid beat%0d: got %b want 0", i, out_valid[0]); end
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    checks += 3;
    if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL latency: out_valid got %b want 1", out_valid[0]); end
    if (z_out[0] !== 8'd48)    begin errors++; $display("FAIL basic_z: got %0d want 48", z_out[0]); end
    if (ovf[0] !== 1'b0)       begin errors++; $display("FAIL basic_ovf: got %b want 0", ovf[0]); end
    finish_eval(0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin ta[i] = 16'sd4096; tw[i] = 16'sd4096; tbv[i] = '0; end
    run_eval(0, 3, 0);
    checks += 2;
    if (z_out[0] !== 8'h7F) begin errors++; $display("FAIL sat_pos_z: got %h want 7f", z_out[0]); end
    if (ovf[0] !== 1'b1)    begin errors++; $display("FAIL sat_pos_ovf: got %b want 1", ovf[0]); end
    finish_eval(0);
    run_eval(1, 3, 0);
    checks += 2;
    if (z_out[1] !== 8'h00) begin errors++; $display("FAIL wrap_z: got %h want 00", z_out[1]); end
    if (ovf[1] !== 1'b1)    begin errors++; $display("FAIL wrap_ovf: got %b want 1", ovf[1]); end
    finish_eval(1);
    for (int i = 0; i < 3; i++) begin ta[i] = -16'sd4096; tw[i] = 16'sd1024; end
    run_eval(0, 3, 0);
    checks += 2;
    if (z_out[0] !== 8'h80) begin errors++; $display("FAIL sat_neg_z: got %h want 80", z_out[0]); end
    if (ovf[0] !== 1'b1)    begin errors++; $display("FAIL sat_neg_ovf: got %b want 1", ovf[0]); end
    finish_eval(0);
  endtask

  task automatic test_floor_single();
    ta[0] = -16'sd1; tw[0] = 16'sd1024; tbv[0] = '0;
    run_eval(2, 1, 0);
    checks += 3;
    if (out_valid[2] !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid[2]); end
    if (z_out[2] !== 8'hFF)    begin errors++; $display("FAIL floor_z: got %h want ff", z_out[2]); end
    if (ovf[2] !== 1'b0)       begin errors++; $display("FAIL floor_ovf: got %b want 0", ovf[2]); end
    finish_eval(2);
  endtask

  task automatic test_bias_once();
    for (int i = 0; i < 3; i++) begin ta[i] = '0; tw[i] = 16'(signed'($urandom)); end
    tbv[0] = 16'sd1024; tbv[1] = 16'sd7777; tbv[2] = -16'sd3000;
    run_eval(0, 3, 1);
    checks += 2;
    if (z_out[0] !== 8'd16) begin errors++; $display("FAIL bias_z: got %0d want 16", z_out[0]); end
    if (ovf[0] !== 1'b0)    begin errors++; $display("FAIL bias_ovf: got %b want 0", ovf[0]); end
    finish_eval(0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin ta[i] = 16'sd1024; tw[i] = 16'sd1024; tbv[i] = '0; end
    run_eval(0, 3, 0);
    in_valid[0] = 1'b1; a_in[0] = 16'sd4096; w_in[0] = 16'sd4096; b_in[0] = 16'sd100;
    for (int c = 0; c < 5; c++) begin
      checks += 3;
      if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL hold_valid cyc%0d: got %b want 1", c, out_valid[0]); end
      if (in_ready[0] !== 1'b0)  begin errors++; $display("FAIL hold_in_ready cyc%0d: got %b want 0", c, in_ready[0]); end
      if (z_out[0] !== 8'd48)    begin errors++; $display("FAIL hold_z cyc%0d: got %0d want 48", c, z_out[0]); end
      @(posedge clk); #1;
    end
    finish_eval(0);
    in_valid[0] = 1'b0;
    checks += 2;
    if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL release_valid: got %b want 0", out_valid[0]); end
    if (in_ready[0] !== 1'b1)  begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready[0]); end
    for (int i = 0; i < 3; i++) ta[i] = 16'sd512;
    run_eval(0, 3, 0);
    checks += 2;
    if (z_out[0] !== 8'd24) begin errors++; $display("FAIL next_eval_z: got %0d want 24", z_out[0]); end
    if (ovf[0] !== 1'b0)    begin errors++; $display("FAIL next_eval_ovf: got %b want 0", ovf[0]); end
    finish_eval(0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin ta[i] = 16'sd4096; tw[i] = 16'sd4096; tbv[i] = '0; end
    run_eval(0, 2, 0);
    #3 reset = 1'b1;
    #1;
    checks += 2;
    if (in_ready[0] !== 1'b1)  begin errors++; $display("FAIL midreset_in_ready: got %b want 1", in_ready[0]); end
    if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", out_valid[0]); end
    #1 reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin ta[i] = 16'sd1024; tw[i] = 16'sd1024; end
    run_eval(0, 3, 0);
    checks += 2;
    if (z_out[0] !== 8'd48) begin errors++; $display("FAIL post_reset_z: got %0d want 48", z_out[0]); end
    if (ovf[0] !== 1'b0)    begin errors++; $display("FAIL post_reset_ovf: got %b want 0", ovf[0]); end
    #3 reset = 1'b1;
    #1;
    checks += 3;
    if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL done_reset_valid: got %b want 0", out_valid[0]); end
    if (z_out[0] !== 8'h00)    begin errors++; $display("FAIL done_reset_z: got %h want 00", z_out[0]); end
    if (in_ready[0] !== 1'b1)  begin errors++; $display("FAIL done_reset_in_ready: got %b want 1", in_ready[0]); end
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int d, input int n, input int count);
    logic [7:0]         ez;
    logic               eovf;
    logic signed [15:0] r;
    int                 sh;
    int                 bad;
    bad = 0;
    for (int k = 0; k < count; k++) begin
      sh = int'($urandom_range(8, 0));
      for (int i = 0; i < n; i++) begin
        r = 16'($urandom); ta[i]  = r >>> sh;
        r = 16'($urandom); tw[i]  = r >>> sh;
        r = 16'($urandom); tbv[i] = r >>> sh;
      end
      model(d, n, ez, eovf);
      run_eval(d, n, 2);
      checks += 3;
      if (out_valid[d] !== 1'b1) begin errors++; bad++; $display("FAIL rand_valid dut%0d eval%0d: got %b want 1", d, k, out_valid[d]); end
      if (z_out[d] !== ez)       begin errors++; bad++; $display("FAIL rand_z dut%0d eval%0d: got %h want %h", d, k, z_out[d], ez); end
      if (ovf[d] !== eovf)       begin errors++; bad++; $display("FAIL rand_ovf dut%0d eval%0d: got %b want %b", d, k, ovf[d], eovf); end
      repeat (int'($urandom_range(2, 0))) begin @(posedge clk); #1; end
      finish_eval(d);
      if (bad > 20) break;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_mac();
    test_saturation();
    test_floor_single();
    test_bias_once();
    test_back_to_back();
    test_async_reset();
    test_random(2, 1, 1000);
    test_random(3, 8, 1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
